// File: rtl/hazard_box_collector.sv
// hazard_box_collector: gathers one frame of hazard boxes into a shadow bank and
// publishes the whole bank atomically on frame commit, so the downstream encoder
// only ever sees complete frames.
//
// Handshake: a box transfers on a rising edge where box_valid and box_ready are
// both high. box_ready is registered and is high exactly while the FSM is in
// COLLECT, so the detector may hold box_valid high across cycles and each
// high-high cycle consumes one box.
module hazard_box_collector #(
    parameter int SLOTS   = 16,
    parameter int COORD_W = 5,
    parameter int CNT_W   = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       frame_start,
    input  logic                       frame_end,
    input  logic                       box_valid,
    output logic                       box_ready,
    input  logic [COORD_W-1:0]         box_top,
    input  logic [COORD_W-1:0]         box_left,
    input  logic [COORD_W-1:0]         box_bottom,
    input  logic [COORD_W-1:0]         box_right,
    output logic [SLOTS*COORD_W-1:0]   top_flat,
    output logic [SLOTS*COORD_W-1:0]   left_flat,
    output logic [SLOTS*COORD_W-1:0]   bottom_flat,
    output logic [SLOTS*COORD_W-1:0]   right_flat,
    output logic [CNT_W-1:0]           num_hazards,
    output logic                       table_valid,
    output logic                       overflow,
    output logic                       bad_box,
    output logic [1:0]                 fsm_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        COMMIT  = 2'd2
    } state_t;

    // Last slot is never written, so it stays zero and capacity is SLOTS-1.
    localparam logic [CNT_W-1:0] CAP = CNT_W'(SLOTS - 1);

    state_t state;

    logic [COORD_W-1:0] sh_top    [SLOTS];
    logic [COORD_W-1:0] sh_left   [SLOTS];
    logic [COORD_W-1:0] sh_bottom [SLOTS];
    logic [COORD_W-1:0] sh_right  [SLOTS];
    logic [CNT_W-1:0]   sh_cnt;
    logic               sh_ovf;
    logic               sh_bad;

    logic do_clear;
    logic do_take;
    logic malformed;

    assign fsm_state = state;

    // Decide whether the shadow bank is wiped or takes a box this cycle.
    // A restart (frame_start without frame_end) in COLLECT wins over a box in
    // the same cycle; a box arriving with frame_end belongs to the closing frame.
    always_comb begin
        do_clear  = 1'b0;
        do_take   = 1'b0;
        malformed = (box_top > box_bottom) || (box_left > box_right);
        case (state)
            IDLE:    do_clear = frame_start;
            COLLECT: begin
                do_clear = frame_start && !frame_end;
                do_take  = box_valid && box_ready && !do_clear;
            end
            COMMIT:  do_clear = frame_start;
            default: ;
        endcase
    end

    // Control FSM with registered box_ready, table_valid and published table.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            box_ready   <= 1'b0;
            table_valid <= 1'b0;
            num_hazards <= '0;
            overflow    <= 1'b0;
            bad_box     <= 1'b0;
            top_flat    <= '0;
            left_flat   <= '0;
            bottom_flat <= '0;
            right_flat  <= '0;
        end else begin
            table_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        state     <= COLLECT;
                        box_ready <= 1'b1;
                    end else begin
                        box_ready <= 1'b0;
                    end
                end
                COLLECT: begin
                    if (frame_end) begin
                        state     <= COMMIT;
                        box_ready <= 1'b0;
                    end else begin
                        box_ready <= 1'b1;
                    end
                end
                COMMIT: begin
                    for (int i = 0; i < SLOTS; i++) begin
                        top_flat[i*COORD_W +: COORD_W]    <= sh_top[i];
                        left_flat[i*COORD_W +: COORD_W]   <= sh_left[i];
                        bottom_flat[i*COORD_W +: COORD_W] <= sh_bottom[i];
                        right_flat[i*COORD_W +: COORD_W]  <= sh_right[i];
                    end
                    num_hazards <= sh_cnt;
                    overflow    <= sh_ovf;
                    bad_box     <= sh_bad;
                    table_valid <= 1'b1;
                    if (frame_start) begin
                        state     <= COLLECT;
                        box_ready <= 1'b1;
                    end else begin
                        state     <= IDLE;
                        box_ready <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    box_ready <= 1'b0;
                end
            endcase
        end
    end

    // Shadow bank: cleared at frame start, filled in arrival order while collecting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_cnt <= '0;
            sh_ovf <= 1'b0;
            sh_bad <= 1'b0;
            for (int i = 0; i < SLOTS; i++) begin
                sh_top[i]    <= '0;
                sh_left[i]   <= '0;
                sh_bottom[i] <= '0;
                sh_right[i]  <= '0;
            end
        end else if (do_clear) begin
            sh_cnt <= '0;
            sh_ovf <= 1'b0;
            sh_bad <= 1'b0;
            for (int i = 0; i < SLOTS; i++) begin
                sh_top[i]    <= '0;
                sh_left[i]   <= '0;
                sh_bottom[i] <= '0;
                sh_right[i]  <= '0;
            end
        end else if (do_take) begin
            if (malformed) begin
                sh_bad <= 1'b1;
            end else if (sh_cnt < CAP) begin
                sh_top[sh_cnt]    <= box_top;
                sh_left[sh_cnt]   <= box_left;
                sh_bottom[sh_cnt] <= box_bottom;
                sh_right[sh_cnt]  <= box_right;
                sh_cnt            <= sh_cnt + 1'b1;
            end else begin
                sh_ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_box_collector.sv
// Bench for hazard_box_collector: directed frames, expected tables queued at
// frame_end and checked by a monitor whenever table_valid pulses.
module tb_hazard_box_collector;

    localparam int SLOTS   = 16;
    localparam int COORD_W = 5;
    localparam int CNT_W   = 4;
    localparam int FW      = SLOTS * COORD_W;
    localparam int TW      = 4 * FW + CNT_W + 2;

    logic               clk;
    logic               rst_n;
    logic               frame_start;
    logic               frame_end;
    logic               box_valid;
    logic               box_ready;
    logic [COORD_W-1:0] box_top;
    logic [COORD_W-1:0] box_left;
    logic [COORD_W-1:0] box_bottom;
    logic [COORD_W-1:0] box_right;
    logic [FW-1:0]      top_flat;
    logic [FW-1:0]      left_flat;
    logic [FW-1:0]      bottom_flat;
    logic [FW-1:0]      right_flat;
    logic [CNT_W-1:0]   num_hazards;
    logic               table_valid;
    logic               overflow;
    logic               bad_box;
    logic [1:0]         fsm_state;

    int checks   = 0;
    int failures = 0;

    // Expected published tables: {top, left, bottom, right, num, overflow, bad}
    logic [TW-1:0] exp_q[$];

    // Expected-table builder
    logic [COORD_W-1:0] e_top [SLOTS];
    logic [COORD_W-1:0] e_left [SLOTS];
    logic [COORD_W-1:0] e_bottom [SLOTS];
    logic [COORD_W-1:0] e_right [SLOTS];
    int                 e_n;
    logic [TW-1:0]      saved_a;

    hazard_box_collector #(
        .SLOTS   (SLOTS),
        .COORD_W (COORD_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .frame_end   (frame_end),
        .box_valid   (box_valid),
        .box_ready   (box_ready),
        .box_top     (box_top),
        .box_left    (box_left),
        .box_bottom  (box_bottom),
        .box_right   (box_right),
        .top_flat    (top_flat),
        .left_flat   (left_flat),
        .bottom_flat (bottom_flat),
        .right_flat  (right_flat),
        .num_hazards (num_hazards),
        .table_valid (table_valid),
        .overflow    (overflow),
        .bad_box     (bad_box),
        .fsm_state   (fsm_state)
    );

    // Clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [FW-1:0] actual,
                         input logic [FW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: actual=%h expected=%h", name, actual, expected);
        end
    endtask

    // Expected-table helpers
    task automatic exp_begin();
        e_n = 0;
        for (int i = 0; i < SLOTS; i++) begin
            e_top[i] = '0; e_left[i] = '0; e_bottom[i] = '0; e_right[i] = '0;
        end
    endtask

    task automatic exp_add(input int t, input int l, input int b, input int r);
        e_top[e_n]    = COORD_W'(t);
        e_left[e_n]   = COORD_W'(l);
        e_bottom[e_n] = COORD_W'(b);
        e_right[e_n]  = COORD_W'(r);
        e_n++;
    endtask

    function automatic logic [TW-1:0] exp_pack(input logic ovf, input logic bad);
        logic [FW-1:0] t, l, b, r;
        for (int i = 0; i < SLOTS; i++) begin
            t[i*COORD_W +: COORD_W] = e_top[i];
            l[i*COORD_W +: COORD_W] = e_left[i];
            b[i*COORD_W +: COORD_W] = e_bottom[i];
            r[i*COORD_W +: COORD_W] = e_right[i];
        end
        return {t, l, b, r, CNT_W'(e_n), ovf, bad};
    endfunction

    task automatic exp_push(input logic ovf, input logic bad);
        exp_q.push_back(exp_pack(ovf, bad));
    endtask

    // Driver tasks: all start and end 1 time unit after a rising edge
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
    endtask

    task automatic pulse_end();
        frame_end = 1'b1;
        tick(1);
        frame_end = 1'b0;
    endtask

    task automatic send_box(input int t, input int l, input int b, input int r,
                            input logic with_end);
        int waited;
        box_top    = COORD_W'(t);
        box_left   = COORD_W'(l);
        box_bottom = COORD_W'(b);
        box_right  = COORD_W'(r);
        box_valid  = 1'b1;
        waited     = 0;
        while (box_ready !== 1'b1 && waited < 20) begin
            tick(1);
            waited++;
        end
        if (box_ready !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL box_ready_timeout: actual=%b expected=1", box_ready);
        end
        frame_end = with_end;
        tick(1);
        box_valid = 1'b0;
        frame_end = 1'b0;
    endtask

    // Monitor: every table_valid pulse must match the oldest expected table
    always @(negedge clk) begin
        if (rst_n && table_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_table_valid: actual=1 expected=0");
            end else begin
                logic [TW-1:0] e;
                e = exp_q.pop_front();
                check("top_flat",    top_flat,    e[TW-1 -: FW]);
                check("left_flat",   left_flat,   e[TW-1-FW -: FW]);
                check("bottom_flat", bottom_flat, e[TW-1-2*FW -: FW]);
                check("right_flat",  right_flat,  e[TW-1-3*FW -: FW]);
                check("num_hazards", FW'(num_hazards), FW'(e[CNT_W+1:2]));
                check("overflow",    FW'(overflow),    FW'(e[1]));
                check("bad_box",     FW'(bad_box),     FW'(e[0]));
            end
        end
    end

    // Stimulus
    initial begin
        rst_n = 1'b0; frame_start = 1'b0; frame_end = 1'b0; box_valid = 1'b0;
        box_top = '0; box_left = '0; box_bottom = '0; box_right = '0;
        e_n = 0;
        #1;
        check("reset_num_hazards", FW'(num_hazards), '0);
        check("reset_top_flat", top_flat, '0);
        check("reset_box_ready", FW'(box_ready), '0);
        check("reset_table_valid", FW'(table_valid), '0);
        check("reset_state", FW'(fsm_state), '0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);

        // 1: two good boxes
        pulse_start();
        check("collect_ready", FW'(box_ready), FW'(1));
        send_box(1, 1, 5, 5, 1'b0);
        send_box(3, 17, 7, 25, 1'b0);
        exp_begin(); exp_add(1, 1, 5, 5); exp_add(3, 17, 7, 25); exp_push(1'b0, 1'b0);
        pulse_end();
        check("commit_ready_low", FW'(box_ready), '0);
        check("tv_latency_low", FW'(table_valid), '0);
        tick(1);
        check("tv_latency_high", FW'(table_valid), FW'(1));
        tick(3);

        // 2: 17 good boxes, only 15 fit
        pulse_start();
        exp_begin();
        for (int i = 1; i <= 17; i++) begin
            send_box(i, i, i + 5, i + 10, 1'b0);
            if (i <= 15) exp_add(i, i, i + 5, i + 10);
        end
        check("full_ready_stays", FW'(box_ready), FW'(1));
        exp_push(1'b1, 1'b0);
        pulse_end();
        tick(4);

        // 3: malformed box between two good ones
        pulse_start();
        send_box(0, 0, 0, 0, 1'b0);
        send_box(6, 0, 2, 4, 1'b0);
        send_box(2, 3, 9, 8, 1'b0);
        exp_begin(); exp_add(0, 0, 0, 0); exp_add(2, 3, 9, 8); exp_push(1'b0, 1'b1);
        pulse_end();
        tick(4);

        // 4: frame A committed, frame B held back
        pulse_start();
        send_box(4, 4, 8, 8, 1'b0);
        send_box(10, 2, 12, 30, 1'b0);
        send_box(31, 31, 31, 31, 1'b0);
        exp_begin(); exp_add(4, 4, 8, 8); exp_add(10, 2, 12, 30); exp_add(31, 31, 31, 31);
        saved_a = exp_pack(1'b0, 1'b0);
        exp_push(1'b0, 1'b0);
        pulse_end();
        tick(3);
        pulse_start();
        send_box(7, 7, 9, 9, 1'b0);
        send_box(5, 6, 5, 6, 1'b0);
        tick(2);
        check("hold_num_hazards", FW'(num_hazards), FW'(3));
        check("hold_top_flat", top_flat, saved_a[TW-1 -: FW]);
        check("hold_right_flat", right_flat, saved_a[TW-1-3*FW -: FW]);
        exp_begin(); exp_add(7, 7, 9, 9); exp_add(5, 6, 5, 6); exp_push(1'b0, 1'b0);
        pulse_end();
        tick(4);

        // 5: frame_end with last box, then frame_start during COMMIT
        pulse_start();
        send_box(1, 2, 3, 4, 1'b0);
        send_box(2, 2, 20, 20, 1'b1);
        exp_begin(); exp_add(1, 2, 3, 4); exp_add(2, 2, 20, 20); exp_push(1'b0, 1'b0);
        pulse_start();
        check("back_to_back_ready", FW'(box_ready), FW'(1));
        send_box(9, 9, 9, 9, 1'b0);
        exp_begin(); exp_add(9, 9, 9, 9); exp_push(1'b0, 1'b0);
        pulse_end();
        tick(4);

        // 6: asynchronous reset mid-frame, then frame_end while idle
        pulse_start();
        send_box(3, 3, 4, 4, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_num_hazards", FW'(num_hazards), '0);
        check("async_top_flat", top_flat, '0);
        check("async_box_ready", FW'(box_ready), '0);
        #2;
        rst_n = 1'b1;
        tick(1);
        pulse_end();
        tick(3);
        check("idle_end_no_tv", FW'(exp_q.size()), '0);
        // fresh empty frame after reset publishes nothing stale
        pulse_start();
        exp_begin(); exp_push(1'b0, 1'b0);
        pulse_end();
        tick(4);

        check("exp_q_drained", FW'(exp_q.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
